// File: rtl/alu_share_arb_if.sv
`timescale 1ns/1ps
// alu_share_arb_if
// Bundles the two request channels, the shared-ALU drive/return signals and
// the response channel of alu_share_arb.
//   slave  modport : the arbiter (takes requests, drives the ALU, returns responses)
//   master modport : the environment (requesters, the ALU itself, the consumer)
// Ports carried:
//   reqN_valid/reqN_ready/reqN_a/reqN_b/reqN_ctr  requester N channel (N = 0 EXU, 1 branch/CSR)
//   alu_a/alu_b/alu_ctr                           shared ALU operands and control
//   alu_out/alu_zero/alu_less                     shared ALU result and flags
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero/rsp_less  response channel
interface alu_share_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTR_WIDTH  = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic [CTR_WIDTH-1:0]  req0_ctr;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic [CTR_WIDTH-1:0]  req1_ctr;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [CTR_WIDTH-1:0]  alu_ctr;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_zero;
    logic                  alu_less;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;
    logic                  rsp_less;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctr,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctr,
        output req1_ready,
        output alu_a, alu_b, alu_ctr,
        input  alu_out, alu_zero, alu_less,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_less,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctr,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctr,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctr,
        output alu_out, alu_zero, alu_less,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_less,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arb.sv
`timescale 1ns/1ps
// alu_share_arb
// Shares one ALU between requester 0 (EXU) and requester 1 (branch/CSR helper).
// One operation is in flight at a time; contention is resolved round-robin.
// Default flow: IDLE --accept--> EXEC --> RESP --rsp handshake--> IDLE.
// In EXEC the latched operands drive the ALU and its outputs are captured
// into the response registers at the end of that cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arb_if.slave : request, ALU and response channels
//
// Optional feature (macro ALU_SHARE_ARB_FASTPATH_EN):
//   EXEC is removed. While any requester is valid the granted requester's
//   inputs drive the ALU combinationally, and the result is captured on the
//   accept edge so the response is valid the next cycle.
//
// DATA_WIDTH and CTR_WIDTH must match the interface instance parameters.
module alu_share_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int CTR_WIDTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

`ifdef ALU_SHARE_ARB_FASTPATH_EN
    localparam logic [1:0] ST_AFTER_ACCEPT = ST_RESP;
`else
    localparam logic [1:0] ST_AFTER_ACCEPT = ST_EXEC;
`endif

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  last_grant_r;
    logic                  grant_s;
    logic                  idle_s;
    logic                  req0_ready_s;
    logic                  req1_ready_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] sel_a_s;
    logic [DATA_WIDTH-1:0] sel_b_s;
    logic [CTR_WIDTH-1:0]  sel_ctr_s;

    logic                  rsp_id_r;
    logic [DATA_WIDTH-1:0] rsp_result_r;
    logic                  rsp_zero_r;
    logic                  rsp_less_r;

    // Round-robin grant: a lone valid requester wins; on contention the one
    // not granted last time wins (last_grant resets to 1, so requester 0 first).
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign idle_s       = (state_r == ST_IDLE);
    assign req0_ready_s = idle_s & bus.req0_valid & ~grant_s;
    assign req1_ready_s = idle_s & bus.req1_valid &  grant_s;
    assign accept_s     = req0_ready_s | req1_ready_s;

    assign bus.req0_ready = req0_ready_s;
    assign bus.req1_ready = req1_ready_s;

    // Operand selection from the granted requester.
    always_comb begin
        sel_a_s   = bus.req0_a;
        sel_b_s   = bus.req0_b;
        sel_ctr_s = bus.req0_ctr;
        if (grant_s) begin
            sel_a_s   = bus.req1_a;
            sel_b_s   = bus.req1_b;
            sel_ctr_s = bus.req1_ctr;
        end else begin
            sel_a_s   = bus.req0_a;
            sel_b_s   = bus.req0_b;
            sel_ctr_s = bus.req0_ctr;
        end
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_AFTER_ACCEPT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and round-robin history (history moves on accept only).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                last_grant_r <= grant_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

`ifdef ALU_SHARE_ARB_FASTPATH_EN
    logic                  any_valid_s;
    logic [DATA_WIDTH-1:0] alu_a_s;
    logic [DATA_WIDTH-1:0] alu_b_s;
    logic [CTR_WIDTH-1:0]  alu_ctr_s;

    assign any_valid_s = bus.req0_valid | bus.req1_valid;

    // ALU follows the granted requester; quiet add-of-zeros when nobody is valid.
    always_comb begin
        alu_a_s   = {DATA_WIDTH{1'b0}};
        alu_b_s   = {DATA_WIDTH{1'b0}};
        alu_ctr_s = {CTR_WIDTH{1'b0}};
        if (any_valid_s) begin
            alu_a_s   = sel_a_s;
            alu_b_s   = sel_b_s;
            alu_ctr_s = sel_ctr_s;
        end else begin
            alu_a_s   = {DATA_WIDTH{1'b0}};
            alu_b_s   = {DATA_WIDTH{1'b0}};
            alu_ctr_s = {CTR_WIDTH{1'b0}};
        end
    end

    assign bus.alu_a   = alu_a_s;
    assign bus.alu_b   = alu_b_s;
    assign bus.alu_ctr = alu_ctr_s;

    // Response capture on the accept edge; the ALU already sees the granted operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {DATA_WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_less_r   <= 1'b0;
        end else if (accept_s) begin
            rsp_id_r     <= grant_s;
            rsp_result_r <= bus.alu_out;
            rsp_zero_r   <= bus.alu_zero;
            rsp_less_r   <= bus.alu_less;
        end else begin
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_zero_r   <= rsp_zero_r;
            rsp_less_r   <= rsp_less_r;
        end
    end
`else
    logic                  op_id_r;
    logic [DATA_WIDTH-1:0] alu_a_r;
    logic [DATA_WIDTH-1:0] alu_b_r;
    logic [CTR_WIDTH-1:0]  alu_ctr_r;

    // The ALU drive registers double as the operand latch: loaded on accept,
    // visible for exactly the EXEC cycle, then returned to the quiet zero value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_id_r   <= 1'b0;
            alu_a_r   <= {DATA_WIDTH{1'b0}};
            alu_b_r   <= {DATA_WIDTH{1'b0}};
            alu_ctr_r <= {CTR_WIDTH{1'b0}};
        end else if (accept_s) begin
            op_id_r   <= grant_s;
            alu_a_r   <= sel_a_s;
            alu_b_r   <= sel_b_s;
            alu_ctr_r <= sel_ctr_s;
        end else if (state_r == ST_EXEC) begin
            op_id_r   <= op_id_r;
            alu_a_r   <= {DATA_WIDTH{1'b0}};
            alu_b_r   <= {DATA_WIDTH{1'b0}};
            alu_ctr_r <= {CTR_WIDTH{1'b0}};
        end else begin
            op_id_r   <= op_id_r;
            alu_a_r   <= alu_a_r;
            alu_b_r   <= alu_b_r;
            alu_ctr_r <= alu_ctr_r;
        end
    end

    assign bus.alu_a   = alu_a_r;
    assign bus.alu_b   = alu_b_r;
    assign bus.alu_ctr = alu_ctr_r;

    // Response capture at the end of EXEC; held through RESP backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {DATA_WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
            rsp_less_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_id_r     <= op_id_r;
            rsp_result_r <= bus.alu_out;
            rsp_zero_r   <= bus.alu_zero;
            rsp_less_r   <= bus.alu_less;
        end else begin
            rsp_id_r     <= rsp_id_r;
            rsp_result_r <= rsp_result_r;
            rsp_zero_r   <= rsp_zero_r;
            rsp_less_r   <= rsp_less_r;
        end
    end
`endif

    assign bus.rsp_valid  = (state_r == ST_RESP);
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_less   = rsp_less_r;

endmodule

// File: tb/tb_alu_share_arb.sv
`timescale 1ns/1ps
// tb_alu_share_arb
// Directed bench for alu_share_arb with a behavioural ALU and a scoreboard:
// the driver pushes the hand-computed response of each issued operation,
// a forked monitor pops and compares on every response handshake.
// ALU codes modelled: 0000 add, 1000 sub, 0001 sll, 0010 slt, 1010 sltu, others 0.
// alu_zero = (a == b); alu_less = ctr[3] ? unsigned a<b : signed a<b.
module tb_alu_share_arb;
    localparam int DW = 32;
    localparam int CW = 4;
`ifdef ALU_SHARE_ARB_FASTPATH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic          zero;
        logic          less;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_share_arb_if #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) bus ();

    alu_share_arb #(.DATA_WIDTH(DW), .CTR_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural shared ALU.
    always_comb begin
        case (bus.alu_ctr)
            4'b0000: bus.alu_out = bus.alu_a + bus.alu_b;
            4'b1000: bus.alu_out = bus.alu_a - bus.alu_b;
            4'b0001: bus.alu_out = bus.alu_a << bus.alu_b[4:0];
            4'b0010: bus.alu_out = {{(DW-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            4'b1010: bus.alu_out = {{(DW-1){1'b0}}, (bus.alu_a < bus.alu_b)};
            default: bus.alu_out = {DW{1'b0}};
        endcase
        bus.alu_zero = (bus.alu_a == bus.alu_b);
        bus.alu_less = bus.alu_ctr[3] ? (bus.alu_a < bus.alu_b)
                                      : ($signed(bus.alu_a) < $signed(bus.alu_b));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input bit id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic set_req(input bit id, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [CW-1:0] ctr);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctr = ctr;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctr = ctr;
        end
    endtask

    // Raise valid and hold it until accepted (bounded); returns just after the accept edge.
    task automatic issue(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] ctr, output bit ok);
        ok = 1'b0;
        set_req(id, 1'b1, a, b, ctr);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy(id)) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        set_req(id, 1'b0, a, b, ctr);
    endtask

    // Wait (bounded) for rsp_valid, returning the number of negedges it took.
    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n = i;
        end
    endtask

    // Full single operation: push expectation, issue, check EXEC drive and latency.
    task automatic do_op(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] ctr, input rsp_t e);
        bit ok;
        int n;
        logic [CW-1:0] exec_ctr;
        exec_ctr = (LAT == 2) ? ctr : 4'd0;
        exp_q.push_back(e);
        issue(id, a, b, ctr, ok);
        check("alu_ctr_after_accept", 64'(bus.alu_ctr), 64'(exec_ctr));
        wait_rsp(n);
        check("latency", 64'(n), 64'(LAT));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int n;
        int n0;
        int n1;
        logic r0;
        logic r1;

        rst_n = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);

        fork
            begin : monitor
                rsp_t got;
                rsp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                        got = {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_less};
                        if (exp_q.size() == 0) begin
                            check("unexpected_rsp{id,res,z,l}", 64'(got), 64'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp{id,res,z,l}", 64'(got), 64'(e));
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("rst_rsp_result", 64'(bus.rsp_result), 64'(0));
        check("rst_rsp_zero", 64'(bus.rsp_zero), 64'(0));
        check("rst_rsp_less", 64'(bus.rsp_less), 64'(0));
        check("rst_alu_a", 64'(bus.alu_a), 64'(0));
        check("rst_alu_b", 64'(bus.alu_b), 64'(0));
        check("rst_alu_ctr", 64'(bus.alu_ctr), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        @(posedge clk);
        #1;

        // Add, signed and unsigned compare.
        do_op(1'b0, 32'd5, 32'd7, 4'b0000, '{id: 1'b0, res: 32'd12, zero: 1'b0, less: 1'b1});
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, '{id: 1'b1, res: 32'd1, zero: 1'b0, less: 1'b1});
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1010, '{id: 1'b1, res: 32'd0, zero: 1'b0, less: 1'b0});
`ifdef ALU_SHARE_ARB_FASTPATH_EN
        do_op(1'b0, 32'd1, 32'd4, 4'b0001, '{id: 1'b0, res: 32'd16, zero: 1'b0, less: 1'b1});
`endif

        // Backpressure: sub 9-9 held while a second request waits.
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{id: 1'b0, res: 32'd0, zero: 1'b1, less: 1'b0});
        issue(1'b0, 32'd9, 32'd9, 4'b1000, ok);
        exp_q.push_back('{id: 1'b1, res: 32'd1, zero: 1'b0, less: 1'b1});
        set_req(1'b1, 1'b1, 32'd2, 32'd3, 4'b0010);
        wait_rsp(n);
        check("bp_latency", 64'(n), 64'(LAT));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("bp_rsp_result", 64'(bus.rsp_result), 64'(0));
            check("bp_rsp_zero", 64'(bus.rsp_zero), 64'(1));
            check("bp_readys_low", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_during_handshake", 64'(bus.req1_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("bp_ready_after_handshake", 64'(bus.req1_ready), 64'(1));
        @(posedge clk);
        #1;
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_rsp(n);
        check("bp_second_latency", 64'(n), 64'(LAT));
        @(posedge clk);
        #1;

        // Reset in the middle of an operation: no response may follow.
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'd3, 32'd4, 4'b1000, ok);
        check("mid_alu_ctr", 64'(bus.alu_ctr), 64'((LAT == 2) ? 4'b1000 : 4'b0000));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_alu_ctr", 64'(bus.alu_ctr), 64'(0));
        check("mid_rst_alu_a", 64'(bus.alu_a), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_stale_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Contention: three operations each, alternating grants starting with 0.
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{id: 1'b0, res: 32'd13, zero: 1'b0, less: 1'b0});
            exp_q.push_back('{id: 1'b1, res: 32'd7,  zero: 1'b0, less: 1'b0});
        end
        set_req(1'b0, 1'b1, 32'd10, 32'd3, 4'b0000);
        set_req(1'b1, 1'b1, 32'd10, 32'd3, 4'b1000);
        @(negedge clk);
        check("first_contention_grant", 64'({bus.req0_ready, bus.req1_ready}), 64'(2'b10));
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 60 && (n0 < 3 || n1 < 3); c++) begin
            if (c != 0) @(negedge clk);
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            check("one_ready", 64'(r0 & r1), 64'(0));
            @(posedge clk);
            if (r0) n0++;
            if (r1) n1++;
            #1;
            bus.req0_valid = (n0 < 3);
            bus.req1_valid = (n1 < 3);
        end
        check("contention_accepts", 64'({n0[7:0], n1[7:0]}), 64'({8'd3, 8'd3}));

        // Drain the scoreboard.
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one ALU instance between two requesters: requester 0 is the EXU, requester 1 is the branch/CSR helper.
- Accepts one operation at a time through a valid/ready handshake and arbitrates round-robin when both requesters are valid.
- Drives the shared ALU operand and control inputs from registered operands, then captures the ALU result, Zero and Less outputs.
- Returns the captured result on a single response channel tagged with the requester id.

Parameters:
- DATA_WIDTH, 32, operand and result width; must equal the ALU data width.
- CTR_WIDTH, 4, width of the ALU control code.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DATA_WIDTH  requester 0 operand A.
- req0_b  in  DATA_WIDTH  requester 0 operand B.
- req0_ctr  in  CTR_WIDTH  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctr: same as requester 0, for requester 1.
- alu_a  out  DATA_WIDTH  shared ALU operand A.
- alu_b  out  DATA_WIDTH  shared ALU operand B.
- alu_ctr  out  CTR_WIDTH  shared ALU control code.
- alu_out  in  DATA_WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctr).
- alu_zero  in  1  ALU A==B flag.
- alu_less  in  1  ALU less flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester the response belongs to.
- rsp_result  out  DATA_WIDTH  captured ALU result.
- rsp_zero  out  1  captured Zero.
- rsp_less  out  1  captured Less.

Behaviour:
- State machine, three states:
  - IDLE -> EXEC on accept (reqN_valid && reqN_ready).
  - EXEC -> RESP unconditionally after one cycle.
  - RESP -> IDLE when rsp_valid && rsp_ready.
- Accept rules:
  - reqN_ready is combinational: asserted only in IDLE and only for the granted requester.
  - At most one ready is asserted per cycle; no accept outside IDLE.
- Arbitration:
  - last_grant register, reset value 1, so requester 0 wins the first contention after reset.
  - Only one valid: that requester is granted.
  - Both valid: grant !last_grant.
  - last_grant updates on accept only.
- On accept, the arbiter latches a, b, ctr and id into internal registers.
- EXEC drives alu_a/alu_b/alu_ctr from the latched registers and captures alu_out/alu_zero/alu_less/id into the response registers at the end of the cycle.
- Outside EXEC, alu_a = 0, alu_b = 0, alu_ctr = 0 (add of zeros); this is a deliberate quiet value.
- rsp_valid = (state == RESP). rsp_id, rsp_result, rsp_zero and rsp_less hold stable while rsp_valid && !rsp_ready.
- Latency: accept at edge N, ALU evaluated in cycle N+1, rsp_valid high from cycle N+2; minimum 3 cycles per operation at full throughput.
- Control codes pass through unchecked; undefined codes return whatever the ALU produces (0).
- Requesters may drop valid without being accepted; no state change results.
- Reset values (also apply on reset mid-operation; the in-flight operation is discarded and no response is produced):
  - state = IDLE, last_grant = 1.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, rsp_less = 0.
  - alu_a = 0, alu_b = 0, alu_ctr = 0.
  - req0_ready and req1_ready follow the IDLE rule once rst_n deasserts.

Optional Feature:
- Macro: ALU_SHARE_ARB_FASTPATH_EN.
- Defined:
  - EXEC state is removed.
  - In IDLE, alu_a/alu_b/alu_ctr are driven combinationally from the granted requester's inputs.
  - The result is captured on the accept edge, and rsp_valid is high the next cycle: latency 1 cycle, 2 cycles per operation.
  - Quiet value applies only when no requester is valid.
- Undefined: three-state behaviour as above.

Test Plan:
- Add: req0 a=5, b=7, ctr=0000 -> rsp_valid 2 cycles after accept; rsp_id=0, rsp_result=12, rsp_zero=0.
- Signed compare: req1 a=0xFFFFFFFF, b=1, ctr=0010 -> rsp_id=1, rsp_result=1, rsp_less=1. Repeat with ctr=1010 -> rsp_result=0, rsp_less=0.
- Contention: both valid continuously, three operations each -> grant order 0,1,0,1,0,1; only one ready high per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a sub 9-9 pending -> rsp_result=0 and rsp_zero=1 held stable; both ready low; accept resumes the cycle after the handshake.
- Reset mid-operation: assert rst_n=0 during EXEC -> rsp_valid=0 immediately and alu_ctr=0; after release, no stale response; first contention grants requester 0.
- Fastpath (macro defined): req0 a=1, b=4, ctr=0001 -> rsp_result=16 one cycle after accept.
